// File: rtl/grover_pkg.sv
// grover_pkg: shared widths, FSM encoding and saturating negate for the 8-state Grover controller
package grover_pkg;
    localparam int NUM_BIT = 3;
    localparam int NUM_SAMPLE = 2 ** NUM_BIT;
    localparam int AMP_W = 8;
    localparam logic signed [AMP_W-1:0] INIT_AMP = AMP_W'(45);
    localparam logic signed [AMP_W-1:0] AMP_MIN = {1'b1, {(AMP_W-1){1'b0}}};
    localparam logic signed [AMP_W-1:0] AMP_MAX = {1'b0, {(AMP_W-1){1'b1}}};
    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_ORACLE = 3'd1;
    localparam logic [2:0] ST_DIFFUSE = 3'd2;
    localparam logic [2:0] ST_FIND = 3'd3;
    localparam logic [2:0] ST_DONE = 3'd4;

    function automatic logic signed [AMP_W-1:0] sat_neg(input logic signed [AMP_W-1:0] a);
        return (a == AMP_MIN) ? AMP_MAX : -a;
    endfunction
endpackage

// File: rtl/grover_argmax_scan.sv
// grover_argmax_scan: walks the 8 amplitudes one per cycle and keeps the lowest index of the largest magnitude
module grover_argmax_scan
    import grover_pkg::*;
(
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          en,
    input  logic [NUM_SAMPLE*AMP_W-1:0]   amps,
    output logic                          last,
    output logic [NUM_BIT-1:0]            result,
    output logic signed [AMP_W-1:0]       max_amp
);
    logic [NUM_BIT-1:0] idx, best_idx;
    logic [AMP_W:0] mag, best_mag;
    logic signed [AMP_W-1:0] cur, best_val;
    logic signed [AMP_W-1:0] lane [NUM_SAMPLE];
    logic take;

    for (genvar k = 0; k < NUM_SAMPLE; k++) begin : g_lane
        assign lane[k] = amps[k*AMP_W +: AMP_W];
    end

    assign cur = lane[idx];
    // one extra bit so the most negative code maps to a positive magnitude
    assign mag = cur[AMP_W-1] ? -{cur[AMP_W-1], cur} : {cur[AMP_W-1], cur};
    assign take = (idx == '0) || (mag > best_mag);
    assign last = en && (&idx);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx <= '0;
            best_idx <= '0;
            best_mag <= '0;
            best_val <= '0;
            result <= '0;
            max_amp <= '0;
        end else if (en) begin
            idx <= idx + NUM_BIT'(1);
            if (take) begin
                best_idx <= idx;
                best_mag <= mag;
                best_val <= cur;
            end
            if (last) begin
                result <= take ? idx : best_idx;
                max_amp <= take ? cur : best_val;
            end
        end
    end
endmodule

// File: rtl/grover_iter_ctrl.sv
// grover_iter_ctrl: runs NUM_ITER oracle/diffuse rounds on 8 amplitudes, then reports the largest-magnitude index
module grover_iter_ctrl
    import grover_pkg::*;
#(
    parameter int NUM_ITER = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [NUM_BIT-1:0]            mark,
    output logic [NUM_SAMPLE*AMP_W-1:0]   amp_out,
    input  logic [NUM_SAMPLE*AMP_W-1:0]   diff_in,
    output logic                          busy,
    output logic                          done,
    output logic [NUM_BIT-1:0]            result,
    output logic signed [AMP_W-1:0]       max_amp
);
    logic [2:0] state;
    logic [NUM_BIT-1:0] mark_q;
    logic [1:0] iter_cnt;
    logic signed [AMP_W-1:0] amp [NUM_SAMPLE];
    logic scan_last;

    for (genvar k = 0; k < NUM_SAMPLE; k++) begin : g_lane
        assign amp_out[k*AMP_W +: AMP_W] = amp[k];
    end

    assign busy = (state == ST_ORACLE) || (state == ST_DIFFUSE) || (state == ST_FIND);
    assign done = (state == ST_DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            mark_q <= '0;
            iter_cnt <= '0;
            for (int i = 0; i < NUM_SAMPLE; i++) amp[i] <= '0;
        end else begin
            case (state)
                ST_IDLE: if (start) begin
                    for (int i = 0; i < NUM_SAMPLE; i++) amp[i] <= INIT_AMP;
                    mark_q <= mark;
                    iter_cnt <= '0;
                    state <= ST_ORACLE;
                end
                ST_ORACLE: begin
                    amp[mark_q] <= sat_neg(amp[mark_q]);
                    state <= ST_DIFFUSE;
                end
                ST_DIFFUSE: begin
                    // external diffuser is combinational on amp_out, so diff_in is already settled
                    for (int i = 0; i < NUM_SAMPLE; i++) amp[i] <= diff_in[i*AMP_W +: AMP_W];
                    if (iter_cnt == 2'(NUM_ITER - 1)) state <= ST_FIND;
                    else begin
                        iter_cnt <= iter_cnt + 2'd1;
                        state <= ST_ORACLE;
                    end
                end
                ST_FIND: if (scan_last) state <= ST_DONE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    grover_argmax_scan u_scan (
        .clk(clk),
        .rst(rst),
        .en(state == ST_FIND),
        .amps(amp_out),
        .last(scan_last),
        .result(result),
        .max_amp(max_amp)
    );
endmodule

// File: tb/tb_grover_iter_ctrl.sv
// tb_grover_iter_ctrl: run-level trajectory model of the Grover controller, checked every cycle under directed and random stimulus
module tb_grover_iter_ctrl;
    localparam int NI = 2;
    localparam int NP = 2 * NI;
    localparam int LAT = 2 * NI + 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic [2:0] mark = '0;
    logic [63:0] amp_out, diff_in;
    logic busy, done;
    logic [2:0] result;
    logic [7:0] max_amp;
    logic fmode = 1'b0;
    logic [63:0] fvec = '0;
    int n_chk = 0;
    int n_fail = 0;
    int dut_dones = 0;

    logic [63:0] traj [0:NP];
    logic [63:0] m_hold = '0;
    bit m_run = 1'b0;
    int m_t = 0;
    int m_dones = 0;
    logic [2:0] m_res = '0;
    logic [7:0] m_max = '0;
    logic [10:0] e_am = '0;

    grover_iter_ctrl #(.NUM_ITER(NI)) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .mark(mark),
        .amp_out(amp_out),
        .diff_in(diff_in),
        .busy(busy),
        .done(done),
        .result(result),
        .max_amp(max_amp)
    );

    initial forever #5 clk = ~clk;

    // inversion about the mean: o = floor(2*mean) - i, wrapped to 8 bits
    function automatic logic [63:0] diffuse(input logic [63:0] v);
        int s;
        logic [63:0] o;
        s = 0;
        for (int k = 0; k < 8; k++) s += int'($signed(v[k*8 +: 8]));
        for (int k = 0; k < 8; k++) o[k*8 +: 8] = 8'((s >>> 2) - int'($signed(v[k*8 +: 8])));
        return o;
    endfunction

    assign diff_in = fmode ? fvec : diffuse(amp_out);

    function automatic logic [7:0] neg(input logic [7:0] a);
        return (a == 8'h80) ? 8'h7f : -a;
    endfunction

    function automatic logic [10:0] argmax(input logic [63:0] v);
        int best, a;
        logic [10:0] r;
        best = -1;
        r = '0;
        for (int k = 0; k < 8; k++) begin
            a = int'($signed(v[k*8 +: 8]));
            if (a < 0) a = -a;
            if (a > best) begin
                best = a;
                r = {3'(k), v[k*8 +: 8]};
            end
        end
        return r;
    endfunction

    function automatic logic [63:0] vec(input int base, input int mk, input int val);
        logic [63:0] v;
        for (int k = 0; k < 8; k++) v[k*8 +: 8] = 8'(base);
        v[mk*8 +: 8] = 8'(val);
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
        n_chk++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, a, e, $time);
        end
    endtask

    // model: whole trajectory computed when a start is accepted, then replayed by edge count
    initial forever begin
        @(posedge clk or posedge rst);
        if (rst) begin
            m_run = 1'b0;
            m_t = 0;
            m_hold = '0;
            m_res = '0;
            m_max = '0;
        end else if (m_run) begin
            m_t++;
            if (m_t == LAT) begin
                m_dones++;
                m_res = e_am[10:8];
                m_max = e_am[7:0];
            end else if (m_t > LAT) begin
                m_run = 1'b0;
                m_hold = traj[NP];
            end
        end else if (start) begin
            traj[0] = {8{8'd45}};
            for (int p = 1; p <= NP; p++) begin
                traj[p] = traj[p-1];
                if (p % 2 == 1) traj[p][mark*8 +: 8] = neg(traj[p-1][mark*8 +: 8]);
                else traj[p] = fmode ? fvec : diffuse(traj[p-1]);
            end
            e_am = argmax(traj[NP]);
            m_run = 1'b1;
            m_t = 0;
        end
    end

    initial forever begin
        @(negedge clk);
        chk("busy", busy, m_run && m_t < LAT);
        chk("done", done, m_run && m_t == LAT);
        chk("amp_out", amp_out, m_run ? traj[m_t < NP ? m_t : NP] : m_hold);
        chk("result", result, m_res);
        chk("max_amp", max_amp, m_max);
        if (done === 1'b1) dut_dones++;
    end

    task automatic run_dir(input logic [2:0] mk, output logic [63:0] s2, output logic [63:0] s3);
        int n;
        s2 = '0;
        s3 = '0;
        start = 1'b1;
        mark = mk;
        @(negedge clk);
        start = 1'b0;
        mark = 3'($urandom);
        n = 0;
        while (done !== 1'b1 && n < 40) begin
            if (n == 2) s2 = amp_out;
            if (n == 3) s3 = amp_out;
            @(negedge clk);
            n++;
            mark = 3'($urandom);
            start = ($urandom_range(0, 2) == 0);
        end
        chk("latency", n, LAT);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        logic [63:0] s2, s3;
        int w;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_amp", amp_out, 64'h0);
        chk("rst_result", result, 3'd0);
        chk("rst_max", max_amp, 8'd0);
        @(negedge clk);

        run_dir(3'd5, s2, s3);
        chk("iter1_m5", s2, vec(22, 5, 112));
        chk("final_m5", amp_out, vec(-12, 5, 122));
        chk("result_m5", result, 3'd5);
        chk("max_m5", max_amp, 8'd122);
        run_dir(3'd0, s2, s3);
        chk("iter1_m0", s2, vec(22, 0, 112));
        chk("final_m0", amp_out, vec(-12, 0, 122));
        chk("result_m0", result, 3'd0);
        run_dir(3'd7, s2, s3);
        chk("iter1_m7", s2, vec(22, 7, 112));
        chk("final_m7", amp_out, vec(-12, 7, 122));
        chk("result_m7", result, 3'd7);

        start = 1'b1;
        mark = 3'd3;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_done", done, 1'b0);
        chk("midrst_amp", amp_out, 64'h0);
        chk("midrst_result", result, 3'd0);
        chk("midrst_max", max_amp, 8'd0);
        @(negedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        run_dir(3'd3, s2, s3);
        chk("result_after_rst", result, 3'd3);
        chk("max_after_rst", max_amp, 8'd122);

        fmode = 1'b1;
        fvec = '0;
        fvec[3*8 +: 8] = 8'h80;
        fvec[6*8 +: 8] = 8'h7f;
        run_dir(3'd2, s2, s3);
        chk("forced_result", result, 3'd3);
        chk("forced_max", max_amp, 8'h80);
        fvec = '0;
        fvec[2*8 +: 8] = 8'h9c;
        fvec[4*8 +: 8] = 8'd100;
        run_dir(3'd6, s2, s3);
        chk("tie_result", result, 3'd2);
        chk("tie_max", max_amp, 8'h9c);
        fvec = '0;
        fvec[1*8 +: 8] = 8'h80;
        run_dir(3'd1, s2, s3);
        chk("sat_neg", s3[15:8], 8'h7f);
        chk("sat_result", result, 3'd1);

        repeat (1200) begin
            if (!m_run) begin
                fmode = ($urandom_range(0, 1) == 1);
                fvec = {$urandom, $urandom};
            end
            start = ($urandom_range(0, 3) == 0);
            mark = 3'($urandom);
            @(negedge clk);
        end
        start = 1'b0;
        w = 0;
        while (m_run && w < 40) begin
            @(negedge clk);
            w++;
        end
        chk("drain", w < 40, 1'b1);
        chk("done_count", dut_dones, m_dones);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/grover_iter_ctrl.md
Name: grover_iter_ctrl

Overview:
- Sequential control stage for the 8-state Grover search datapath; sits directly upstream of the combinational inversion-about-mean diffuser.
- Holds the 8 amplitude registers and initialises them to a uniform superposition.
- Each iteration: applies the oracle phase flip to the marked index, drives the flipped amplitudes into the diffuser, and registers the diffuser's outputs.
- After NUM_ITER iterations, scans for the largest-magnitude amplitude and reports its index.

Parameters:
- NUM_BIT, 3, index width; NUM_SAMPLE = 2**NUM_BIT = 8 amplitudes
- AMP_W, 8, signed amplitude width; Q1.7 format, scale 128
- INIT_AMP, 45, uniform start amplitude: round(128/sqrt(8))
- NUM_ITER, 2, Grover iterations, range 1..3

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  one-cycle request; sampled only in IDLE
- mark  in  NUM_BIT  marked index; latched on accepted start
- amp_out  out  8*AMP_W  amplitude registers to the diffuser; lane k = bits [8k+7:8k] -> diffuser input ik
- diff_in  in  8*AMP_W  diffuser outputs; lane k <- diffuser output ok
- busy  out  1  high from the cycle after an accepted start until DONE
- done  out  1  one-cycle pulse; result and max_amp valid from this cycle
- result  out  NUM_BIT  index of the largest |amplitude|
- max_amp  out  AMP_W  signed amplitude at result

Behaviour:
- Reset (async, any state): state=IDLE; all amplitude registers=0; result=0; max_amp=0; busy=0; done=0; iteration and scan counters=0.
- States: IDLE, ORACLE, DIFFUSE, FIND, DONE.
- IDLE, start=1:
  - all amps <= INIT_AMP; latch mark; iter_cnt <= 0.
  - -> ORACLE; busy=1 from next cycle.
- ORACLE (1 cycle):
  - amp[mark] <= -amp[mark]; others hold.
  - Negation saturates: -(-128) = +127.
  - -> DIFFUSE.
- DIFFUSE (1 cycle):
  - all amps <= diff_in (diffuser is combinational on amp_out, so its result is valid the same cycle).
  - If iter_cnt == NUM_ITER-1: -> FIND, scan idx <= 0.
  - Else: iter_cnt++, -> ORACLE.
- FIND (8 cycles, idx 0..7):
  - Each cycle compare |amp[idx]| against the running best; abs is computed at AMP_W+1 bits so -128 -> 128.
  - idx 0 unconditionally loads best.
  - Strictly-greater replaces best, so ties keep the lowest index.
  - At idx 7, result/max_amp are registered and state -> DONE.
- DONE (1 cycle): done=1, busy=0; -> IDLE.
- result/max_amp hold until the next completed run or reset.
- Amplitude registers hold after the run and stay visible on amp_out.
- Latency: done is high in the cycle after the (2*NUM_ITER+8)th rising edge following the start-sampling edge; 12 edges for NUM_ITER=2.
- start while not in IDLE (including DONE): ignored, no queueing. mark changes while busy: ignored.
- start asserted in the IDLE cycle immediately after DONE: accepted normally.
- Reset mid-run: run aborted, no done pulse.
- Diffuser overflow wraps inside the diffuser; this block registers diff_in verbatim.

Decomposition:
- Shared package grover_pkg holds:
  - NUM_BIT, NUM_SAMPLE, AMP_W, INIT_AMP
  - state encoding constants, 3 bits: IDLE=0, ORACLE=1, DIFFUSE=2, FIND=3, DONE=4
  - the saturating-negate function
- One natural sub-module: grover_argmax_scan, which owns the idx counter, the abs compare, and the best-value/best-index registers.
- The diffuser stays external and is instantiated beside this block at the next level up.

Test Plan:
- Reset mid-run: assert rst during the ORACLE of iteration 2 -> all outputs 0 immediately, no done pulse; a fresh start afterwards completes normally.
- mark=5, NUM_ITER=2, real diffuser attached:
  - after iteration 1, amps = 22 everywhere except amp5 = 112
  - final amps = -12 everywhere except amp5 = 122
  - done at edge 12, result=5, max_amp=122
- mark=0 and mark=7: same values mirrored -> result=0 / result=7; checks lane ordering of amp_out and diff_in.
- start pulses during busy and in the DONE cycle -> ignored; exactly one done per accepted start; busy deasserted in the done cycle.
- Forced diffuser model returning amp3=-128, amp6=+127, rest 0:
  - -> result=3, max_amp=-128 (magnitude compare)
  - two equal maxima at lanes 2 and 4 -> result=2
- Saturation: forced diff_in lane 1 = -128 with mark=1, next ORACLE -> amp_out lane 1 = +127.
